mem_lsu_stage: RTL and testbench
================================

# mem_lsu_stage

Parametrised memory-access (MEM) stage of the 5-stage pipeline, sitting between the execute/EX-MEM register and the MEM-WB register. Replaces the single-width, word-only MEM stage with sub-word loads/stores (byte enables, sign/zero extension), a request/ready handshake FSM that stalls the pipeline until the data memory answers, a bus-timeout and misalignment fault path, and branch resolution. Resolves branches when the stage advances and drives the redirect and flush outputs to the fetch stage.

## Interface
- XLEN, 32: datapath width, 32 or 64; lanes = XLEN/8.
- AW, 32: data address width.
- TIMEOUT, 255: max ACCESS cycles before bus fault; ≥2.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- keep / nop  in  1  external hold / bubble-insert for the MEM-WB register.
- RegWrite_pype2, MemBranch_pype2[2:0], MemtoReg_pype2[1:0], MemRW_pype2[1:0]  in  control from EX (MemRW: 01 store, 10 load, 00 none).
- PCBranch_pype, PCp4_pype2, ALU_co_pype, read_data2_pype2  in  XLEN  branch target, PC+4, ALU result/address, store data.
- WReg_pype2  in  5;  Instraction_pype2  in  32 (funct3 = bits 14:12).
- daddr  out  AW;  dreq, dwrite  out  1;  dbe  out  lanes;  ddata  inout  XLEN.
- dready_n  in  1  active-low completion;  dbusy  in  1  memory cannot accept a request.
- RegWrite_pype3, MemtoReg_pype3, WReg_pype3, ALU_co_w_pype, PCp4_pype3, Instraction_pype3  out  registered MEM-WB fields.
- mem_data_pype  out  XLEN  registered, aligned, extended load data.
- stall  out  1  combinational; upstream stages hold while high.
- mem_fault  out  1  one-cycle pulse on misalign or timeout.
- branch_PC  out  XLEN;  branch_PC_contral, branch_nop  out  1.

## Operation
- FSM states: IDLE, WAITBUS, ACCESS, DONE.
- IDLE: no memory op (MemRW=00) or nop=1 → no stall, pipeline advances normally. Memory op with nop=0: misaligned → DONE with fault; dbusy=1 → WAITBUS; else → ACCESS. stall=1 in the same cycle.
- WAITBUS: dreq=0, stall=1. Go to ACCESS when dbusy=0.
- ACCESS: dreq=1, dwrite=MemRW[0], and daddr/dbe/ddata are held stable. The timeout counter increments each cycle.
  - dready_n=0: capture the extracted load data into mem_data_pype and go to DONE.
  - Counter reaches TIMEOUT-1 with dready_n still high: pulse mem_fault and go to DONE.
- DONE: stall=0, dreq=0. Return to IDLE on the first edge with keep=0; stay in DONE while keep=1.
- A faulted op writes RegWrite_pype3=0.
- Misalignment rules:
  - Half access with addr[0]≠0 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Double access (XLEN=64 only) with addr[2:0]≠0 is misaligned.
  - funct3=011 with XLEN=32 is treated as misaligned.
- Stores:
  - Data is replicated into every lane.
  - dbe one-hot, pair, quad, or all lanes, selected by the address low bits.
  - ddata is driven only while dreq&dwrite; high-Z otherwise.
- Loads: lane selected by the address.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
  - LWU/LD exist only when XLEN=64.
- Branch taken when any of:
  - BEQ and ALU==0
  - BNE and ALU≠0
  - BGE and ALU==0
  - BLT and ALU==1
  - JAL
- On a taken branch, the advancing edge registers branch_PC=PCBranch_pype, branch_PC_contral=1, branch_nop=1. Otherwise both flags are 0.
- MEM-WB register update priority: rst > keep > nop > stall > normal.
  - keep holds all fields.
  - nop zeroes the control fields and branch flags; PCp4 and Instraction are held.
  - stall=1 holds all fields.
- nop or keep arriving in WAITBUS or ACCESS does not abort the bus transaction. The result lands and is discarded if nop applies at the advancing edge.

## Timing
- Reset: all outputs 0, FSM in IDLE, counter 0, ddata high-Z.
  - Reset mid-ACCESS drops dreq immediately (asynchronous).
- Non-memory instruction: 1 cycle in the stage, no stall.
- Memory op with zero-wait memory: IDLE (stall) → ACCESS (dready_n=0, stall) → DONE (advance). That is 3 cycles and 2 stall cycles.
- Each WAITBUS cycle or dready_n-high cycle adds exactly one cycle.
- Timeout: dreq stays high for exactly TIMEOUT cycles. mem_fault is asserted in the cycle the FSM enters DONE.
- Misaligned op: IDLE → DONE, 1 stall cycle, no dreq ever asserted.
- Back-to-back memory ops: the second op's IDLE cycle immediately follows the first op's DONE cycle. No dead cycle beyond that.

## Structure
- Shared package (define.v): MEMB_* branch codes, load/store funct3 codes, FSM state encodings, MemRW encodings.
- Sub-module mem_lsu_align: purely combinational. Computes store lane replication, dbe, load extraction/extension and the misalign flag from funct3, addr low bits and XLEN. Instantiated once.
- Top level holds the FSM, timeout counter, branch logic and MEM-WB registers.

## Test plan
- XLEN=32, SB addr 0x1003 data 0xA5, zero-wait memory: dbe=1000, ddata=0xA5A5A5A5, 2 stall cycles, RegWrite_pype3=0.
- LB addr 0x2001, memory returns 0x0000_8000 after 3 dready_n-high cycles: mem_data_pype=0xFFFF_FF80, stall for 5 cycles. LBU of the same data gives 0x0000_0080.
- LW addr 0x2002: no dreq, mem_fault pulse, 1 stall cycle, RegWrite_pype3=0.
- TIMEOUT=4, load with dready_n held high: dreq high for exactly 4 cycles, then mem_fault, then advance.
- BNE with ALU=5 and PCBranch=0x40: next edge gives branch_PC=0x40 and branch_PC_contral=branch_nop=1. The same op with nop=1 gives both flags 0.
- dbusy high 2 cycles, then load, with keep asserted in DONE and rst pulsed mid-ACCESS on a second run: FSM passes WAITBUS→ACCESS, holds in DONE under keep, and all outputs clear asynchronously on rst.

Source files
------------

// File: rtl/mem_lsu_stage_pkg.sv
// Shared encodings for the MEM stage: FSM states, branch codes, access sizes
// and the MemRW control field.
package mem_lsu_stage_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITBUS = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_DONE    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MEMB_NONE = 3'd0;
  localparam logic [2:0] MEMB_BEQ  = 3'd1;
  localparam logic [2:0] MEMB_BNE  = 3'd2;
  localparam logic [2:0] MEMB_BGE  = 3'd3;
  localparam logic [2:0] MEMB_BLT  = 3'd4;
  localparam logic [2:0] MEMB_JAL  = 3'd5;

  // funct3[1:0] is the access size; funct3[2] selects zero extension
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] MEMRW_NONE = 2'b00;
  localparam logic [1:0] MEMRW_ST   = 2'b01;
  localparam logic [1:0] MEMRW_LD   = 2'b10;
endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store replication, byte enables, load
// extraction with sign/zero extension, and the misalignment flag.
module mem_lsu_align
  import mem_lsu_stage_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int LB = $clog2(LANES)
) (
  input  logic [2:0]       funct3_i,
  input  logic [LB-1:0]    addr_lo_i,
  input  logic [XLEN-1:0]  st_raw_i,
  input  logic [XLEN-1:0]  ld_raw_i,
  output logic [XLEN-1:0]  st_data_o,
  output logic [LANES-1:0] dbe_o,
  output logic [XLEN-1:0]  ld_data_o,
  output logic             misalign_o
);
  logic [1:0]      size;
  logic [XLEN-1:0] ld_sh;
  logic            sbit;
  int              nbytes, nbits, off;

  always_comb begin
    size       = funct3_i[1:0];
    off        = int'(addr_lo_i);
    nbytes     = 1 << size;
    nbits      = (8 * nbytes > XLEN) ? XLEN : 8 * nbytes;
    st_data_o  = st_raw_i;
    misalign_o = 1'b0;
    unique case (size)
      SZ_B: for (int i = 0; i < LANES; i++) st_data_o[i*8 +: 8] = st_raw_i[7:0];
      SZ_H: begin
        for (int i = 0; i < LANES / 2; i++) st_data_o[i*16 +: 16] = st_raw_i[15:0];
        misalign_o = addr_lo_i[0];
      end
      SZ_W: begin
        for (int i = 0; i < LANES / 4; i++) st_data_o[i*32 +: 32] = st_raw_i[31:0];
        misalign_o = |addr_lo_i[1:0];
      end
      default: misalign_o = (XLEN != 64) || (|addr_lo_i);
    endcase

    ld_sh = ld_raw_i >> {addr_lo_i, 3'b000};
    sbit  = 1'b0;
    unique case (size)
      SZ_B:    sbit = ld_sh[7];
      SZ_H:    sbit = ld_sh[15];
      SZ_W:    sbit = ld_sh[31];
      default: sbit = ld_sh[XLEN-1];
    endcase
    sbit = sbit & ~funct3_i[2];
    for (int j = 0; j < XLEN; j++) ld_data_o[j] = (j < nbits) ? ld_sh[j] : sbit;
    for (int i = 0; i < LANES; i++) dbe_o[i] = (i >= off) && (i < off + nbytes);
  end
endmodule

// File: rtl/mem_lsu_stage.sv
// MEM stage: bus handshake FSM with timeout, misalign fault, branch
// resolution and the MEM-WB pipeline register.
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keep,
  input  logic              nop,
  input  logic              RegWrite_pype2,
  input  logic [2:0]        MemBranch_pype2,
  input  logic [1:0]        MemtoReg_pype2,
  input  logic [1:0]        MemRW_pype2,
  input  logic [XLEN-1:0]   PCBranch_pype,
  input  logic [XLEN-1:0]   PCp4_pype2,
  input  logic [XLEN-1:0]   ALU_co_pype,
  input  logic [XLEN-1:0]   read_data2_pype2,
  input  logic [4:0]        WReg_pype2,
  input  logic [31:0]       Instraction_pype2,
  output logic [AW-1:0]     daddr,
  output logic              dreq,
  output logic              dwrite,
  output logic [XLEN/8-1:0] dbe,
  inout  wire  [XLEN-1:0]   ddata,
  input  logic              dready_n,
  input  logic              dbusy,
  output logic              RegWrite_pype3,
  output logic [1:0]        MemtoReg_pype3,
  output logic [4:0]        WReg_pype3,
  output logic [XLEN-1:0]   ALU_co_w_pype,
  output logic [XLEN-1:0]   PCp4_pype3,
  output logic [31:0]       Instraction_pype3,
  output logic [XLEN-1:0]   mem_data_pype,
  output logic              stall,
  output logic              mem_fault,
  output logic [XLEN-1:0]   branch_PC,
  output logic              branch_PC_contral,
  output logic              branch_nop
);
  localparam int LB = $clog2(XLEN / 8);
  localparam int CW = $clog2(TIMEOUT);

  lsu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              fault_q, fault_set, cap;
  logic [XLEN-1:0]   rdata_q, st_data, ld_ext;
  logic [XLEN/8-1:0] be;
  logic              mis, memop, is_st, taken;

  assign memop = (MemRW_pype2 == MEMRW_ST) || (MemRW_pype2 == MEMRW_LD);
  assign is_st = (MemRW_pype2 == MEMRW_ST);

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i   (Instraction_pype2[14:12]),
    .addr_lo_i  (ALU_co_pype[LB-1:0]),
    .st_raw_i   (read_data2_pype2),
    .ld_raw_i   (ddata),
    .st_data_o  (st_data),
    .dbe_o      (be),
    .ld_data_o  (ld_ext),
    .misalign_o (mis)
  );

  // Request fields come straight from the EX-MEM register, which the stall holds steady.
  assign dreq   = (state_q == ST_ACCESS);
  assign dwrite = dreq & is_st;
  assign daddr  = dreq ? ALU_co_pype[AW-1:0] : '0;
  assign dbe    = dreq ? be : '0;
  assign ddata  = dwrite ? st_data : 'z;

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    fault_set = 1'b0;
    cap       = 1'b0;
    unique case (state_q)
      ST_IDLE: if (memop && !nop) begin
        stall = 1'b1;
        if (mis) begin
          state_d   = ST_DONE;
          fault_set = 1'b1;
        end else if (dbusy) state_d = ST_WAITBUS;
        else                state_d = ST_ACCESS;
      end
      ST_WAITBUS: begin
        stall = 1'b1;
        if (!dbusy) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (!dready_n) begin
          state_d = ST_DONE;
          cap     = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          fault_set = 1'b1;
        end
      end
      ST_DONE: if (!keep) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case (MemBranch_pype2)
      MEMB_BEQ: taken = (ALU_co_pype == '0);
      MEMB_BNE: taken = (ALU_co_pype != '0);
      MEMB_BGE: taken = (ALU_co_pype == '0);
      MEMB_BLT: taken = (ALU_co_pype == XLEN'(1));
      MEMB_JAL: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

  // Load data is parked in rdata_q so the MEM-WB copy only changes on the advancing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      mem_fault <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= (state_q == ST_ACCESS) ? cnt_q + 1'b1 : '0;
      fault_q   <= fault_set | (fault_q && state_q == ST_DONE && state_d == ST_DONE);
      mem_fault <= fault_set;
      if (cap) rdata_q <= ld_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite_pype3    <= 1'b0;
      MemtoReg_pype3    <= '0;
      WReg_pype3        <= '0;
      ALU_co_w_pype     <= '0;
      PCp4_pype3        <= '0;
      Instraction_pype3 <= '0;
      mem_data_pype     <= '0;
      branch_PC         <= '0;
      branch_PC_contral <= 1'b0;
      branch_nop        <= 1'b0;
    end else if (keep) begin
      // hold everything
    end else if (nop) begin
      RegWrite_pype3    <= 1'b0;
      MemtoReg_pype3    <= '0;
      WReg_pype3        <= '0;
      branch_PC_contral <= 1'b0;
      branch_nop        <= 1'b0;
    end else if (!stall) begin
      RegWrite_pype3    <= RegWrite_pype2 & ~fault_q;
      MemtoReg_pype3    <= MemtoReg_pype2;
      WReg_pype3        <= WReg_pype2;
      ALU_co_w_pype     <= ALU_co_pype;
      PCp4_pype3        <= PCp4_pype2;
      Instraction_pype3 <= Instraction_pype2;
      mem_data_pype     <= rdata_q;
      if (taken) branch_PC <= PCBranch_pype;
      branch_PC_contral <= taken;
      branch_nop        <= taken;
    end
  end
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage (XLEN=32, TIMEOUT=4) with a simple
// memory responder driving ddata and dready_n.
module tb_mem_lsu_stage;
  import mem_lsu_stage_pkg::*;

  logic        clk, rst, keep, nop;
  logic        RegWrite_pype2;
  logic [2:0]  MemBranch_pype2;
  logic [1:0]  MemtoReg_pype2, MemRW_pype2;
  logic [31:0] PCBranch_pype, PCp4_pype2, ALU_co_pype, read_data2_pype2;
  logic [4:0]  WReg_pype2;
  logic [31:0] Instraction_pype2;
  logic [31:0] daddr;
  logic        dreq, dwrite;
  logic [3:0]  dbe;
  wire  [31:0] ddata;
  logic        dready_n, dbusy;
  logic        RegWrite_pype3;
  logic [1:0]  MemtoReg_pype3;
  logic [4:0]  WReg_pype3;
  logic [31:0] ALU_co_w_pype, PCp4_pype3, Instraction_pype3, mem_data_pype, branch_PC;
  logic        stall, mem_fault, branch_PC_contral, branch_nop;
  logic [31:0] mem_val;
  int          checks, failures;

  assign ddata = (dreq && !dwrite) ? mem_val : 'z;

  mem_lsu_stage #(.XLEN(32), .AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .RegWrite_pype2(RegWrite_pype2), .MemBranch_pype2(MemBranch_pype2),
    .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
    .PCBranch_pype(PCBranch_pype), .PCp4_pype2(PCp4_pype2),
    .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
    .WReg_pype2(WReg_pype2), .Instraction_pype2(Instraction_pype2),
    .daddr(daddr), .dreq(dreq), .dwrite(dwrite), .dbe(dbe), .ddata(ddata),
    .dready_n(dready_n), .dbusy(dbusy),
    .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
    .WReg_pype3(WReg_pype3), .ALU_co_w_pype(ALU_co_w_pype),
    .PCp4_pype3(PCp4_pype3), .Instraction_pype3(Instraction_pype3),
    .mem_data_pype(mem_data_pype), .stall(stall), .mem_fault(mem_fault),
    .branch_PC(branch_PC), .branch_PC_contral(branch_PC_contral),
    .branch_nop(branch_nop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    keep = 0; nop = 0; RegWrite_pype2 = 0; MemBranch_pype2 = MEMB_NONE;
    MemtoReg_pype2 = 0; MemRW_pype2 = MEMRW_NONE; PCBranch_pype = 0;
    PCp4_pype2 = 0; ALU_co_pype = 0; read_data2_pype2 = 0; WReg_pype2 = 0;
    Instraction_pype2 = 0; dready_n = 1; dbusy = 0;
  endtask

  task automatic set_op(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rwe);
    MemRW_pype2       = rw;
    Instraction_pype2 = {17'h0, f3, 5'd7, (rw == MEMRW_ST) ? 7'h23 : 7'h03};
    ALU_co_pype       = addr;
    read_data2_pype2  = wd;
    RegWrite_pype2    = rwe;
    MemtoReg_pype2    = (rw == MEMRW_LD) ? 2'd1 : 2'd0;
    WReg_pype2        = 5'd7;
    PCp4_pype2        = 32'h100;
    MemBranch_pype2   = MEMB_NONE;
    nop               = 0;
  endtask

  // Runs one op until its advancing edge, playing the memory side and counting events.
  task automatic run_op(input int busy_n, input int wait_n, input int keep_n,
                        output int nst, output int ndq, output int nflt,
                        output logic wr_s, output logic [3:0] be_s, output logic [31:0] dd_s,
                        output logic [31:0] ad_s, output logic keep_ok, output logic [31:0] md_keep,
                        output logic to);
    int  cyc;
    logic fin;
    nst = 0; ndq = 0; nflt = 0; wr_s = 0; be_s = 0; dd_s = 0; ad_s = 0;
    keep_ok = 1; md_keep = 0; to = 0; cyc = 0; fin = 0;
    while (!fin) begin
      dbusy = (cyc < busy_n);
      #1;
      if (mem_fault) nflt++;
      if (dreq) begin
        if (ndq == 0) begin wr_s = dwrite; be_s = dbe; dd_s = ddata; ad_s = daddr; end
        dready_n = (ndq >= wait_n) ? 1'b0 : 1'b1;
        ndq++;
      end
      if (stall) nst++; else fin = 1;
      if (!fin) begin
        @(posedge clk); #1; cyc++;
        if (cyc > 60) begin to = 1; fin = 1; end
      end
    end
    for (int k = 0; k < keep_n; k++) begin
      keep = 1;
      @(posedge clk); #2;
      if (stall || dreq) keep_ok = 0;
      if (mem_fault) nflt++;
      md_keep = mem_data_pype;
    end
    keep = 0;
    @(posedge clk); #2;
    if (mem_fault) nflt++;
    clear_inputs();
  endtask

  task automatic test_reset();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (dreq !== 1'b0 || dbe !== 4'h0 || daddr !== 32'h0) begin failures++;
      $display("FAIL reset_bus got dreq=%b dbe=%h daddr=%h exp 0", dreq, dbe, daddr); end
    checks++; if (RegWrite_pype3 !== 1'b0 || mem_data_pype !== 32'h0 || mem_fault !== 1'b0) begin failures++;
      $display("FAIL reset_regs got rw=%b md=%h flt=%b exp 0", RegWrite_pype3, mem_data_pype, mem_fault); end
    checks++; if (branch_PC !== 32'h0 || branch_PC_contral !== 1'b0 || branch_nop !== 1'b0) begin failures++;
      $display("FAIL reset_branch got pc=%h c=%b n=%b exp 0", branch_PC, branch_PC_contral, branch_nop); end
    rst = 0;
  endtask

  task automatic test_store();
    int nst, ndq, nflt; logic wr, kok, to; logic [3:0] be; logic [31:0] dd, ad, mk;
    set_op(MEMRW_ST, 3'b000, 32'h1003, 32'h0000_00A5, 1'b0);
    run_op(0, 0, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (to) begin failures++; $display("FAIL sb_timeout_bound got=hang exp=done"); end
    checks++; if (wr !== 1'b1 || be !== 4'b1000 || ad !== 32'h1003) begin failures++;
      $display("FAIL sb_bus got wr=%b be=%b ad=%h exp 1 1000 1003", wr, be, ad); end
    checks++; if (dd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_ddata got=%h exp=a5a5a5a5", dd); end
    checks++; if (nst != 2 || ndq != 1) begin failures++; $display("FAIL sb_stalls got st=%0d dq=%0d exp 2 1", nst, ndq); end
    checks++; if (RegWrite_pype3 !== 1'b0) begin failures++; $display("FAIL sb_regwrite got=%b exp=0", RegWrite_pype3); end
  endtask

  task automatic test_load_ext();
    int nst, ndq, nflt; logic wr, kok, to; logic [3:0] be; logic [31:0] dd, ad, mk;
    mem_val = 32'h0000_8000;
    set_op(MEMRW_LD, 3'b000, 32'h2001, 32'h0, 1'b1);
    run_op(0, 3, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (to || nst != 5 || ndq != 4) begin failures++;
      $display("FAIL lb_timing got st=%0d dq=%0d to=%b exp 5 4 0", nst, ndq, to); end
    checks++; if (mem_data_pype !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", mem_data_pype); end
    checks++; if (RegWrite_pype3 !== 1'b1 || WReg_pype3 !== 5'd7 || MemtoReg_pype3 !== 2'd1) begin failures++;
      $display("FAIL lb_ctrl got rw=%b wr=%0d m2r=%0d exp 1 7 1", RegWrite_pype3, WReg_pype3, MemtoReg_pype3); end
    checks++; if (ALU_co_w_pype !== 32'h2001 || PCp4_pype3 !== 32'h100 || Instraction_pype3 !== 32'h0000_0383) begin failures++;
      $display("FAIL lb_fields got alu=%h pc4=%h ins=%h exp 2001 100 383", ALU_co_w_pype, PCp4_pype3, Instraction_pype3); end
    set_op(MEMRW_LD, 3'b100, 32'h2001, 32'h0, 1'b1);
    run_op(0, 3, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (mem_data_pype !== 32'h0000_0080 || nflt != 0) begin failures++;
      $display("FAIL lbu_data got=%h flt=%0d exp=00000080 0", mem_data_pype, nflt); end
  endtask

  task automatic test_timeout();
    int nst, ndq, nflt; logic wr, kok, to; logic [3:0] be; logic [31:0] dd, ad, mk;
    set_op(MEMRW_LD, 3'b010, 32'h2004, 32'h0, 1'b1);
    run_op(0, 100, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (to || ndq != 4 || nst != 5) begin failures++;
      $display("FAIL timeout_len got dq=%0d st=%0d to=%b exp 4 5 0", ndq, nst, to); end
    checks++; if (nflt != 1 || RegWrite_pype3 !== 1'b0) begin failures++;
      $display("FAIL timeout_fault got flt=%0d rw=%b exp 1 0", nflt, RegWrite_pype3); end
  endtask

  task automatic test_back_to_back();
    int nst, ndq, nflt; logic wr, kok, to; logic [3:0] be; logic [31:0] dd, ad, mk;
    mem_val = 32'h8001_0000;
    set_op(MEMRW_LD, 3'b001, 32'h3002, 32'h0, 1'b1);
    run_op(0, 0, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (nst != 2 || mem_data_pype !== 32'hFFFF_8001) begin failures++;
      $display("FAIL b2b_lh got st=%0d md=%h exp 2 ffff8001", nst, mem_data_pype); end
    mem_val = 32'h0000_F00F;
    set_op(MEMRW_LD, 3'b101, 32'h3000, 32'h0, 1'b1);
    run_op(0, 0, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (nst != 2 || mem_data_pype !== 32'h0000_F00F || be !== 4'b0011) begin failures++;
      $display("FAIL b2b_lhu got st=%0d md=%h be=%b exp 2 0000f00f 0011", nst, mem_data_pype, be); end
  endtask

  task automatic test_misalign();
    int nst, ndq, nflt; logic wr, kok, to; logic [3:0] be; logic [31:0] dd, ad, mk;
    set_op(MEMRW_LD, 3'b010, 32'h2002, 32'h0, 1'b1);
    run_op(0, 0, 0, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (nst != 1 || ndq != 0 || nflt != 1) begin failures++;
      $display("FAIL lw_misalign got st=%0d dq=%0d flt=%0d exp 1 0 1", nst, ndq, nflt); end
    checks++; if (RegWrite_pype3 !== 1'b0) begin failures++; $display("FAIL lw_misalign_rw got=%b exp=0", RegWrite_pype3); end
  endtask

  typedef struct { logic [2:0] br; logic [31:0] alu; logic [31:0] pcb; logic exp; } br_vec_t;

  task automatic test_branch();
    br_vec_t v [6];
    v[0] = '{MEMB_BNE, 32'd5, 32'h40,  1'b1};
    v[1] = '{MEMB_BEQ, 32'd5, 32'h60,  1'b0};
    v[2] = '{MEMB_BEQ, 32'd0, 32'h80,  1'b1};
    v[3] = '{MEMB_BLT, 32'd1, 32'hC0,  1'b1};
    v[4] = '{MEMB_BGE, 32'd1, 32'hE0,  1'b0};
    v[5] = '{MEMB_JAL, 32'd7, 32'h200, 1'b1};
    for (int i = 0; i < 6; i++) begin
      MemBranch_pype2 = v[i].br; ALU_co_pype = v[i].alu; PCBranch_pype = v[i].pcb;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL br%0d_stall got=%b exp=0", i, stall); end
      @(posedge clk); #2;
      checks++; if (branch_PC_contral !== v[i].exp || branch_nop !== v[i].exp ||
                    (v[i].exp && branch_PC !== v[i].pcb)) begin failures++;
        $display("FAIL br%0d got pc=%h c=%b n=%b exp taken=%b pc=%h", i, branch_PC,
                 branch_PC_contral, branch_nop, v[i].exp, v[i].pcb); end
    end
    MemBranch_pype2 = MEMB_BNE; ALU_co_pype = 32'd5; PCBranch_pype = 32'h44; nop = 1;
    @(posedge clk); #2;
    checks++; if (branch_PC_contral !== 1'b0 || branch_nop !== 1'b0) begin failures++;
      $display("FAIL br_nop got c=%b n=%b exp 0 0", branch_PC_contral, branch_nop); end
    clear_inputs();
  endtask

  task automatic test_busy_keep_reset();
    int nst, ndq, nflt; logic wr, kok, to; logic [3:0] be; logic [31:0] dd, ad, mk;
    mem_val = 32'h1234_5678;
    set_op(MEMRW_LD, 3'b010, 32'h4000, 32'h0, 1'b1);
    run_op(2, 0, 2, nst, ndq, nflt, wr, be, dd, ad, kok, mk, to);
    checks++; if (to || nst != 4 || ndq != 1) begin failures++;
      $display("FAIL busy_timing got st=%0d dq=%0d to=%b exp 4 1 0", nst, ndq, to); end
    checks++; if (kok !== 1'b1 || mk !== 32'h0000_F00F) begin failures++;
      $display("FAIL keep_hold got ok=%b md=%h exp 1 0000f00f", kok, mk); end
    checks++; if (mem_data_pype !== 32'h1234_5678 || RegWrite_pype3 !== 1'b1) begin failures++;
      $display("FAIL keep_release got md=%h rw=%b exp 12345678 1", mem_data_pype, RegWrite_pype3); end
    set_op(MEMRW_LD, 3'b010, 32'h4000, 32'h0, 1'b1);
    @(posedge clk); #2;
    checks++; if (dreq !== 1'b1) begin failures++; $display("FAIL rst_pre_dreq got=%b exp=1", dreq); end
    @(posedge clk); #2;
    rst = 1;
    #1;
    checks++; if (dreq !== 1'b0 || daddr !== 32'h0 || dbe !== 4'h0) begin failures++;
      $display("FAIL rst_async_bus got dreq=%b ad=%h be=%h exp 0", dreq, daddr, dbe); end
    checks++; if (RegWrite_pype3 !== 1'b0 || mem_data_pype !== 32'h0 || WReg_pype3 !== 5'd0) begin failures++;
      $display("FAIL rst_async_regs got rw=%b md=%h wr=%0d exp 0", RegWrite_pype3, mem_data_pype, WReg_pype3); end
    clear_inputs();
    @(posedge clk); #2;
    rst = 0;
    #1;
    checks++; if (stall !== 1'b0 || dreq !== 1'b0) begin failures++;
      $display("FAIL post_rst_idle got st=%b dreq=%b exp 0 0", stall, dreq); end
  endtask

  initial begin
    checks = 0; failures = 0; mem_val = 0;
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    @(posedge clk); #2;
    test_store();
    test_load_ext();
    test_timeout();
    test_back_to_back();
    test_misalign();
    test_branch();
    test_busy_keep_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
